// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_pkg
//  Description : Shared types and default constants for the iterative
//                multiply/divide sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

    // Iterations per operation for 32-bit operands
    localparam int c_MULT_STEPS = 16;   // radix-4 Booth
    localparam int c_DIV_STEPS  = 32;   // restoring division
    localparam int c_CNT_W      = 6;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/multdiv_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_sequencer_if
//  Description : Issue-side starts, datapath strobes and result handshake of
//                the multiply/divide sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multdiv_sequencer_if
    import multdiv_pkg::*;
#(
    parameter int CNT_W = c_CNT_W
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic             divisor_zero;
    logic             mult_ovf;
    logic             dp_load;
    logic             dp_step;
    logic             dp_op_div;
    logic [CNT_W-1:0] dp_step_idx;
    logic             busy;
    logic             data_resultRDY;
    logic             data_exception;

    // Issue logic / datapath status side
    modport master (
        output ctrl_MULT, ctrl_DIV, divisor_zero, mult_ovf,
        input  dp_load, dp_step, dp_op_div, dp_step_idx, busy,
               data_resultRDY, data_exception
    );

    // Sequencer side
    modport slave (
        input  ctrl_MULT, ctrl_DIV, divisor_zero, mult_ovf,
        output dp_load, dp_step, dp_op_div, dp_step_idx, busy,
               data_resultRDY, data_exception
    );
endinterface
`default_nettype wire

// File: rtl/iter_counter.sv
`default_nettype none
// ============================================================================
//  Module      : iter_counter
//  Description : CNT_W-bit up-counter built from T flip-flops, with
//                synchronous clear (priority) and count enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module iter_counter #(
    parameter int CNT_W = 6
)(
    input  wire             clk,
    input  wire             i_clr,
    input  wire             i_en,
    output wire [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] w_q;
    logic [CNT_W-1:0] w_toggle;

    // Bit k toggles when enabled and all lower bits are 1 (ripple-free carry
    // computed from the flop outputs, so there is no combinational chain).
    for (genvar k = 0; k < CNT_W; k++) begin : g_bit
        if (k == 0) begin : g_lsb
            assign w_toggle[k] = i_en;
        end else begin : g_upper
            assign w_toggle[k] = i_en & (&w_q[k-1:0]);
        end

        tff_cell u_tff (
            .clk (clk),
            .rst (i_clr),
            .i_t (w_toggle[k]),
            .o_q (w_q[k])
        );
    end

    assign o_cnt = w_q;
endmodule
`default_nettype wire

// File: rtl/tff_cell.sv
`default_nettype none
// ============================================================================
//  Module      : tff_cell
//  Description : T flip-flop with synchronous clear (clear has priority).
//  Revision    : 1.0 - initial release
// ============================================================================
module tff_cell (
    input  wire clk,
    input  wire rst,
    input  wire i_t,
    output wire o_q
);
    logic r_q;

    // Toggle on T, synchronous clear wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (i_t) begin
            r_q <= ~r_q;
        end
    end

    assign o_q = r_q;
endmodule
`default_nettype wire

// File: rtl/multdiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_sequencer
//  Description : Control FSM for the iterative multiply/divide unit. Accepts
//                MULT/DIV start pulses, drives datapath load/step strobes for
//                a fixed iteration count and emits a one-cycle result-ready
//                pulse with an exception flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int MULT_STEPS = c_MULT_STEPS,
    parameter int DIV_STEPS  = c_DIV_STEPS,
    parameter int CNT_W      = c_CNT_W
)(
    input wire                 clock,
    input wire                 reset,
    multdiv_sequencer_if.slave bus
);
    // Step counts must fit the iteration counter
    if ((MULT_STEPS < 1) || (MULT_STEPS > (1 << CNT_W)) ||
        (DIV_STEPS  < 1) || (DIV_STEPS  > (1 << CNT_W))) begin : g_bad_steps
        $error("multdiv_sequencer: MULT_STEPS/DIV_STEPS must be in 1..2**CNT_W");
    end

    localparam logic [CNT_W-1:0] c_MULT_LAST = CNT_W'(MULT_STEPS - 1);
    localparam logic [CNT_W-1:0] c_DIV_LAST  = CNT_W'(DIV_STEPS - 1);

    state_t           r_state;
    state_t           w_next;
    logic             r_op_div;
    logic             r_divzero;
    logic [CNT_W-1:0] w_cnt;
    logic             w_start;
    logic             w_last;
    logic             w_clr;
    logic             w_en;

    logic             w_load;
    logic             w_step;
    logic             w_op_div;
    logic [CNT_W-1:0] w_idx;
    logic             w_busy;
    logic             w_rdy;
    logic             w_exc;

    assign w_start = bus.ctrl_MULT | bus.ctrl_DIV;
    assign w_last  = (w_cnt == (r_op_div ? c_DIV_LAST : c_MULT_LAST));

    // Counter is zeroed by reset, any (re)start, LOAD and the final RUN step
    assign w_clr = reset | w_start | (r_state == LOAD) |
                   ((r_state == RUN) && w_last);
    assign w_en  = (r_state == RUN);

    iter_counter #(
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk   (clock),
        .i_clr (w_clr),
        .i_en  (w_en),
        .o_cnt (w_cnt)
    );

    // State register plus op/divzero capture on every start edge
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_op_div  <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_op_div  <= ~bus.ctrl_MULT;     // MULT wins a tie
                r_divzero <= bus.divisor_zero;
            end
        end
    end

    // Next-state: sequence LOAD->RUN->DONE; a start always restarts at LOAD
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: w_next = IDLE;
            LOAD: w_next = (r_op_div && r_divzero) ? DONE : RUN;
            RUN:  w_next = w_last ? DONE : RUN;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_start) begin
            w_next = LOAD;
        end
    end

    // Moore outputs decoded from state and counter
    always_comb begin
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_op_div = 1'b0;
        w_idx    = '0;
        w_busy   = 1'b0;
        w_rdy    = 1'b0;
        w_exc    = 1'b0;
        case (r_state)
            LOAD: begin
                w_load   = 1'b1;
                w_op_div = r_op_div;
                w_busy   = 1'b1;
            end
            RUN: begin
                w_step   = 1'b1;
                w_op_div = r_op_div;
                w_idx    = w_cnt;
                w_busy   = 1'b1;
            end
            DONE: begin
                w_busy = 1'b1;
                w_rdy  = 1'b1;
                w_exc  = r_op_div ? r_divzero : bus.mult_ovf;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    assign bus.dp_load        = w_load;
    assign bus.dp_step        = w_step;
    assign bus.dp_op_div      = w_op_div;
    assign bus.dp_step_idx    = w_idx;
    assign bus.busy           = w_busy;
    assign bus.data_resultRDY = w_rdy;
    assign bus.data_exception = w_exc;
endmodule
`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multdiv_sequencer
//  Description : Self-checking bench for multdiv_sequencer. Cycle 0 is the
//                cycle in which the start pulse is driven; outputs are
//                sampled 1 time unit after each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;

    multdiv_sequencer_if ifc ();

    multdiv_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clock = ~clock;

    // Packed view: load, step, op_div, idx[5:0], busy, rdy, exc
    logic [11:0] outs;
    assign outs = {ifc.dp_load, ifc.dp_step, ifc.dp_op_div, ifc.dp_step_idx,
                   ifc.busy, ifc.data_resultRDY, ifc.data_exception};

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        string       name;
        int          cyc;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [11:0] pk(input bit ld, input bit st, input bit od,
                                       input int idx, input bit by, input bit rd,
                                       input bit ex);
        return {ld, st, od, 6'(idx), by, rd, ex};
    endfunction

    // Expected outputs for an op whose LOAD cycle is L with S steps
    function automatic logic [11:0] model(input int c, input int L, input bit dv,
                                          input int S, input bit dz, input bit ex);
        int dn;
        dn = dz ? L + 1 : L + S + 1;
        if (c == L)                       return pk(1, 0, dv, 0, 1, 0, 0);
        if (!dz && (c > L) && (c < dn))   return pk(0, 1, dv, c - L - 1, 1, 0, 0);
        if (c == dn)                      return pk(0, 0, 0, 0, 1, 1, ex);
        return 12'h000;
    endfunction

    task automatic check(input string nm, input logic [11:0] exp, input logic [11:0] mask);
        checks++;
        if ((outs & mask) !== (exp & mask)) begin
            errors++;
            $display("FAIL %s cycle %0d: got %03h expected %03h (load,step,opdiv,idx,busy,rdy,exc)",
                     nm, cyc, outs & mask, exp & mask);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        ifc.ctrl_MULT = 1'b0;
        ifc.ctrl_DIV  = 1'b0;
    endtask

    // Check cycles from..to (cyc must equal from on entry); op_div is
    // don't-care in the DONE cycle.
    task automatic check_range(input string nm, input int from, input int to,
                               input int L, input bit dv, input int S,
                               input bit dz, input bit ex);
        int dn;
        dn = dz ? L + 1 : L + S + 1;
        for (int n = from; n <= to; n++) begin
            check(nm, model(cyc, L, dv, S, dz, ex), (cyc == dn) ? 12'hDFF : 12'hFFF);
            tick();
        end
    endtask

    task automatic start(input bit m, input bit d);
        cyc = 0;
        ifc.ctrl_MULT = m;
        ifc.ctrl_DIV  = d;
        check("idle_before_start", 12'h000, 12'hFFF);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.ctrl_MULT    = 1'b0;
        ifc.ctrl_DIV     = 1'b0;
        ifc.divisor_zero = 1'b0;
        ifc.mult_ovf     = 1'b0;

        // Reset, with a start pulse that reset must override
        reset = 1'b1;
        tick();
        ifc.ctrl_MULT = 1'b1;
        tick();
        check("reset_state", 12'h000, 12'hFFF);
        reset = 1'b0;
        tick();
        check("after_reset", 12'h000, 12'hFFF);

        // 1. Multiply, table-driven spot checks, mult_ovf held high
        tbl[0] = '{"mul_c0_idle",  0, pk(0, 0, 0, 0, 0, 0, 0)};
        tbl[1] = '{"mul_c1_load",  1, pk(1, 0, 0, 0, 1, 0, 0)};
        tbl[2] = '{"mul_c2_step0", 2, pk(0, 1, 0, 0, 1, 0, 0)};
        tbl[3] = '{"mul_c3_step1", 3, pk(0, 1, 0, 1, 1, 0, 0)};
        tbl[4] = '{"mul_c10_step8",10, pk(0, 1, 0, 8, 1, 0, 0)};
        tbl[5] = '{"mul_c17_step15",17, pk(0, 1, 0, 15, 1, 0, 0)};
        tbl[6] = '{"mul_c18_done", 18, pk(0, 0, 0, 0, 1, 1, 1)};
        tbl[7] = '{"mul_c19_idle", 19, pk(0, 0, 0, 0, 0, 0, 0)};
        ifc.mult_ovf  = 1'b1;
        cyc           = 0;
        ifc.ctrl_MULT = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            foreach (tbl[i]) begin
                if (tbl[i].cyc == cyc) check(tbl[i].name, tbl[i].exp, 12'hFFF);
            end
            tick();
        end

        // 2. Divide, normal (mult_ovf high must not leak into exception)
        ifc.divisor_zero = 1'b0;
        start(1'b0, 1'b1);
        check_range("div_normal", 1, 36, 1, 1'b1, 32, 1'b0, 1'b0);

        // 3. Divide by zero; divisor_zero dropped after the start edge
        ifc.divisor_zero = 1'b1;
        ifc.mult_ovf     = 1'b0;
        start(1'b0, 1'b1);
        ifc.divisor_zero = 1'b0;
        check_range("div_by_zero", 1, 6, 1, 1'b1, 32, 1'b1, 1'b1);

        // 4. Restart: MULT at cycle 0, DIV at cycle 8
        ifc.mult_ovf = 1'b1;
        start(1'b1, 1'b0);
        check_range("restart_mul", 1, 7, 1, 1'b0, 16, 1'b0, 1'b1);
        ifc.ctrl_DIV = 1'b1;
        check_range("restart_mul", 8, 8, 1, 1'b0, 16, 1'b0, 1'b1);
        check_range("restart_div", 9, 45, 9, 1'b1, 32, 1'b0, 1'b0);

        // 5. Reset in cycle 5 of a multiply, then a clean divide
        start(1'b1, 1'b0);
        check_range("rstmid_mul", 1, 4, 1, 1'b0, 16, 1'b0, 1'b1);
        reset = 1'b1;
        check_range("rstmid_mul", 5, 5, 1, 1'b0, 16, 1'b0, 1'b1);
        reset = 1'b0;
        check_range("rstmid_idle", 6, 25, 1000, 1'b0, 16, 1'b0, 1'b0);
        start(1'b0, 1'b1);
        check_range("rstmid_div", 1, 36, 1, 1'b1, 32, 1'b0, 1'b0);

        // 6a. Simultaneous starts: multiply wins despite divisor_zero
        ifc.divisor_zero = 1'b1;
        ifc.mult_ovf     = 1'b0;
        start(1'b1, 1'b1);
        ifc.divisor_zero = 1'b0;
        check_range("both_start", 1, 19, 1, 1'b0, 16, 1'b0, 1'b0);

        // 6b. New MULT in the DONE cycle
        ifc.mult_ovf = 1'b1;
        start(1'b1, 1'b0);
        check_range("done_restart", 1, 17, 1, 1'b0, 16, 1'b0, 1'b1);
        ifc.ctrl_MULT = 1'b1;
        check_range("done_restart", 18, 18, 1, 1'b0, 16, 1'b0, 1'b1);
        check_range("done_restart2", 19, 38, 19, 1'b0, 16, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
